// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO of {instr, pc} between fetch and FD; optional FETCH_QUEUE_BYPASS_EN fall-through.
// Latency: 1 cycle empty-to-head (0 cycles with FETCH_QUEUE_BYPASS_EN when empty and ready_i is high).
// Backpressure: ready_o deasserts when full, from state only; flush_i drops everything, including a same-cycle offer.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic [INSTR_W-1:0]         instr_i,
    input  logic [PC_W-1:0]            pc_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [INSTR_W-1:0]         instr_o,
    output logic [PC_W-1:0]            pc_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [INSTR_W-1:0] NOP = INSTR_W'(32'h0000_0013);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    logic [CNT_W-1:0]   count;
    logic               notEmpty;
    logic               bypass;
    logic               enqFire;
    logic               deqFire;
    entry_t             head;

    assign notEmpty = (count != '0);
    assign head     = mem[rdPtr];

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue with a consumer waiting: hand the fetch straight through, never stored.
    assign bypass = ~notEmpty & valid_i & ready_i & ~flush_i;
`else
    assign bypass = 1'b0;
`endif

    assign ready_o = (count != CNT_W'(DEPTH));
    assign valid_o = bypass | (notEmpty & ~flush_i);

    always_comb begin
        instr_o = NOP;
        pc_o    = '0;
        if (bypass) begin
            instr_o = instr_i;
            pc_o    = pc_i;
        end else if (notEmpty) begin
            instr_o = head.instr;
            pc_o    = head.pc;
        end
    end

    assign enqFire = valid_i & ready_o & ~flush_i & ~bypass;
    assign deqFire = valid_o & ready_i & ~bypass;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (enqFire) wrPtr <= wrPtr + PTR_W'(1);
            if (deqFire) rdPtr <= rdPtr + PTR_W'(1);
            if (enqFire && !deqFire)      count <= count + CNT_W'(1);
            else if (deqFire && !enqFire) count <= count - CNT_W'(1);
        end
    end

    // Storage is not reset; count gates every read.
    always_ff @(posedge clk_i) begin
        if (enqFire) mem[wrPtr] <= '{instr: instr_i, pc: pc_i};
    end

    assign count_o = count;
endmodule
